multi_channel_timer: RTL

- Parametrised successor to the front-panel single timer. Provides NUM_CHANNELS independent counters, each with a runtime-programmable period, periodic or one-shot mode, start/stop control and compare match.
- Feeds front-panel scan, debounce and LED-blink logic from one shared tick enable.

---
 rtl/multi_channel_timer_if.sv | 29 ++
 rtl/multi_channel_timer.sv | 98 +++++++++
 2 files changed

// File: rtl/multi_channel_timer_if.sv
// Control and status bundle for multi_channel_timer: per-channel strobes,
// programmed periods/compare values in, counts and status flags out.
interface multi_channel_timer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int TIMER_WIDTH  = 8
);
  logic                              clk_en;
  logic [NUM_CHANNELS-1:0]           start;
  logic [NUM_CHANNELS-1:0]           stop;
  logic [NUM_CHANNELS-1:0]           oneshot;
  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] period;
  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] compare;
  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] timer_value;
  logic [NUM_CHANNELS-1:0]           running;
  logic [NUM_CHANNELS-1:0]           half_elapsed;
  logic [NUM_CHANNELS-1:0]           overflowing;
  logic [NUM_CHANNELS-1:0]           compare_match;
  logic [NUM_CHANNELS-1:0]           done;

  modport master (
    output clk_en, start, stop, oneshot, period, compare,
    input  timer_value, running, half_elapsed, overflowing, compare_match, done
  );

  modport slave (
    input  clk_en, start, stop, oneshot, period, compare,
    output timer_value, running, half_elapsed, overflowing, compare_match, done
  );
endinterface

// File: rtl/multi_channel_timer.sv
// NUM_CHANNELS independent IDLE/RUN timers sharing one count enable, each with
// a period and mode latched at start, live compare, and a one-shot done pulse.
module multi_channel_timer #(
  parameter int NUM_CHANNELS = 4,
  parameter int TIMER_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  multi_channel_timer_if.slave bus
);
  localparam int N = NUM_CHANNELS;
  localparam int W = TIMER_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q [N];
  state_t         state_d [N];
  logic [W-1:0]   count_q [N];
  logic [W-1:0]   count_d [N];
  logic [W-1:0]   plat_q  [N];
  logic [W-1:0]   plat_d  [N];
  logic [N-1:0]   mode_q, mode_d;
  logic [N-1:0]   done_q, done_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        count_q[i] <= '0;
        plat_q[i]  <= '0;
      end
      mode_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
        plat_q[i]  <= plat_d[i];
      end
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end

  // Priority per channel: stop, then start (a zero period freezes the channel
  // for that cycle), then enabled counting.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      plat_d[i]  = plat_q[i];
    end
    mode_d = mode_q;
    done_d = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.stop[i]) begin
        state_d[i] = IDLE;
      end else if (bus.start[i]) begin
        if (bus.period[i*W +: W] != '0) begin
          state_d[i] = RUN;
          count_d[i] = '0;
          plat_d[i]  = bus.period[i*W +: W];
          mode_d[i]  = bus.oneshot[i];
        end
      end else if (state_q[i] == RUN && bus.clk_en) begin
        if (count_q[i] == plat_q[i] - ONE) begin
          count_d[i] = '0;
          if (mode_q[i]) begin
            state_d[i] = IDLE;
            done_d[i]  = 1'b1;
          end
        end else begin
          count_d[i] = count_q[i] + ONE;
        end
      end
    end
  end

  // Half-period match is gated on Plat >= 2 so (Plat>>1)-1 never wraps to all-ones.
  always_comb begin
    bus.timer_value   = '0;
    bus.running       = '0;
    bus.half_elapsed  = '0;
    bus.overflowing   = '0;
    bus.compare_match = '0;
    for (int i = 0; i < N; i++) begin
      bus.timer_value[i*W +: W] = count_q[i];
      bus.running[i]       = (state_q[i] == RUN);
      bus.overflowing[i]   = (state_q[i] == RUN) && (count_q[i] == plat_q[i] - ONE);
      bus.half_elapsed[i]  = (state_q[i] == RUN) && (plat_q[i][W-1:1] != '0) &&
                             (count_q[i] == (plat_q[i] >> 1) - ONE);
      bus.compare_match[i] = (state_q[i] == RUN) && (count_q[i] == bus.compare[i*W +: W]);
    end
  end

  assign bus.done = done_q;
endmodule
